// File: rtl/carrier_lock_ctrl.sv
// carrier_lock_ctrl
//   Acquisition/tracking sequencer for the QAM16 carrier-recovery loop.
//   Averages |pd| from the decision-directed phase detector over windows
//   of 2**WIN_LOG2 symbols, steps the NCO sweep offset while searching,
//   picks the loop-filter gain and declares carrier lock.
//
// Ports
//   clk         in   system clock (8 MHz)
//   rst         in   asynchronous reset, active-low
//   en          in   controller enable; low forces IDLE and clears the window
//   bitsync     in   one-clk symbol strobe; pd is valid 2 clks later
//   pd          in   signed phase-detector word
//   sweep_freq  out  signed frequency offset to the NCO
//   gain_sel    out  loop-filter gain: 0 wide, 1 medium, 2 narrow
//   freeze      out  hold loop-filter integrator (IDLE, SWEEP)
//   lock        out  carrier locked
//   state       out  0 IDLE, 1 SWEEP, 2 PULL, 3 TRACK
//   err_mean    out  last window mean |pd|   (only with CLC_ERR_MON_EN)
//   err_valid   out  one-clk window strobe   (only with CLC_ERR_MON_EN)
//
// Build option
//   CLC_ERR_MON_EN : exposes the window mean and its strobe.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | disabled, outputs at reset values
// SWEEP | stepping sweep_freq each window until a good window
// PULL  | medium gain, counting consecutive good windows
// TRACK | narrow gain, locked; counting consecutive bad windows

module carrier_lock_ctrl #(
    parameter int              PDW        = 34,
    parameter int              FW         = 32,
    parameter int              WIN_LOG2   = 6,
    parameter logic [PDW-1:0]  LOCK_TH    = 34'd4000000,
    parameter logic [PDW-1:0]  UNLOCK_TH  = 34'd9000000,
    parameter int              LOCK_CNT   = 4,
    parameter int              LOSS_CNT   = 3,
    parameter logic [FW-1:0]   SWEEP_STEP = 32'd20000,
    parameter logic [FW-1:0]   SWEEP_MAX  = 32'd2000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  bitsync,
    input  logic signed [PDW-1:0] pd,
    output logic signed [FW-1:0]  sweep_freq,
    output logic [1:0]            gain_sel,
    output logic                  freeze,
    output logic                  lock,
    output logic [1:0]            state
`ifdef CLC_ERR_MON_EN
    ,
    output logic [PDW-1:0]        err_mean,
    output logic                  err_valid
`endif
);

    localparam int AW = PDW + WIN_LOG2;
    localparam logic [3:0] LOCK_CNT_W = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_CNT_W = 4'(LOSS_CNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        PULL  = 2'd2,
        TRACK = 2'd3
    } state_t;

    state_t state_q, state_n;
    logic signed [FW-1:0] sweep_n;
    logic [3:0] good_cnt_q, good_cnt_n;
    logic [3:0] bad_cnt_q, bad_cnt_n;
    logic [1:0] gain_n;
    logic       freeze_n;
    logic       lock_n;

    // ------------------------------------------------------------------
    // Sample strobe and window averaging
    // ------------------------------------------------------------------
    logic                bs_d1;
    logic                samp;
    logic [PDW-1:0]      pd_abs;
    logic [AW-1:0]       acc;
    logic [AW-1:0]       acc_sum;
    logic [AW-1:0]       mean_full;
    logic [WIN_LOG2-1:0] sym_cnt;
    logic                run;
    logic                win_done;
    logic                win_good;
    logic                win_bad;

    // Negating the most-negative word would wrap back to itself.
    always_comb begin
        pd_abs = pd;
        if (pd[PDW-1]) begin
            if (pd == {1'b1, {(PDW-1){1'b0}}})
                pd_abs = {1'b0, {(PDW-1){1'b1}}};
            else
                pd_abs = -pd;
        end
    end

    assign acc_sum   = acc + {{WIN_LOG2{1'b0}}, pd_abs};
    assign mean_full = acc_sum >> WIN_LOG2;
    assign run       = en && (state_q != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bs_d1    <= 1'b0;
            samp     <= 1'b0;
            acc      <= '0;
            sym_cnt  <= '0;
            win_done <= 1'b0;
            win_good <= 1'b0;
            win_bad  <= 1'b0;
`ifdef CLC_ERR_MON_EN
            err_mean <= '0;
`endif
        end else begin
            bs_d1    <= bitsync;
            samp     <= bs_d1;
            win_done <= 1'b0;
            if (!run) begin
                acc     <= '0;
                sym_cnt <= '0;
            end else if (samp) begin
                sym_cnt <= sym_cnt + WIN_LOG2'(1);
                if (&sym_cnt) begin
                    acc      <= '0;
                    win_done <= 1'b1;
                    win_good <= mean_full <  {{WIN_LOG2{1'b0}}, LOCK_TH};
                    win_bad  <= mean_full >= {{WIN_LOG2{1'b0}}, UNLOCK_TH};
`ifdef CLC_ERR_MON_EN
                    err_mean <= mean_full[PDW-1:0];
`endif
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

`ifdef CLC_ERR_MON_EN
    assign err_valid = win_done;
`endif

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic signed [FW:0] sw_sum;
    logic signed [FW:0] sw_lim;

    assign sw_sum = $signed({sweep_freq[FW-1], sweep_freq})
                  + $signed({SWEEP_STEP[FW-1], SWEEP_STEP});
    assign sw_lim = $signed({1'b0, SWEEP_MAX});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sweep_freq <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            gain_sel   <= 2'd0;
            freeze     <= 1'b1;
            lock       <= 1'b0;
        end else begin
            state_q    <= state_n;
            sweep_freq <= sweep_n;
            good_cnt_q <= good_cnt_n;
            bad_cnt_q  <= bad_cnt_n;
            gain_sel   <= gain_n;
            freeze     <= freeze_n;
            lock       <= lock_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        sweep_n    = sweep_freq;
        good_cnt_n = good_cnt_q;
        bad_cnt_n  = bad_cnt_q;

        if (!en) begin
            state_n    = IDLE;
            sweep_n    = '0;
            good_cnt_n = '0;
            bad_cnt_n  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_n = SWEEP;
                end
                SWEEP: begin
                    if (win_done) begin
                        if (win_good) begin
                            state_n    = PULL;
                            good_cnt_n = 4'd1;
                        end else if (sw_sum > sw_lim) begin
                            sweep_n = FW'(0) - SWEEP_MAX;
                        end else begin
                            sweep_n = sw_sum[FW-1:0];
                        end
                    end
                end
                PULL: begin
                    if (win_done) begin
                        if (win_good) begin
                            if (good_cnt_q + 4'd1 >= LOCK_CNT_W) begin
                                state_n    = TRACK;
                                good_cnt_n = '0;
                                bad_cnt_n  = '0;
                            end else begin
                                good_cnt_n = good_cnt_q + 4'd1;
                            end
                        end else if (win_bad) begin
                            state_n    = SWEEP;
                            good_cnt_n = '0;
                        end
                    end
                end
                TRACK: begin
                    if (win_done) begin
                        if (win_bad) begin
                            if (bad_cnt_q + 4'd1 >= LOSS_CNT_W) begin
                                state_n   = SWEEP;
                                bad_cnt_n = '0;
                            end else begin
                                bad_cnt_n = bad_cnt_q + 4'd1;
                            end
                        end else begin
                            bad_cnt_n = '0;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they register with it.
        gain_n   = 2'd0;
        freeze_n = 1'b1;
        lock_n   = 1'b0;
        case (state_n)
            PULL: begin
                gain_n   = 2'd1;
                freeze_n = 1'b0;
            end
            TRACK: begin
                gain_n   = 2'd2;
                freeze_n = 1'b0;
                lock_n   = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_carrier_lock_ctrl.sv
module tb_carrier_lock_ctrl;

    localparam logic signed [33:0] PD_MIN = 34'sh2_0000_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               bitsync;
    logic signed [33:0] pd;
    logic signed [31:0] sweep_freq;
    logic [1:0]         gain_sel;
    logic               freeze;
    logic               lock;
    logic [1:0]         state;
`ifdef CLC_ERR_MON_EN
    logic [33:0]        err_mean;
    logic               err_valid;
`endif

    carrier_lock_ctrl #(
        .PDW(34), .FW(32), .WIN_LOG2(2),
        .LOCK_CNT(2), .LOSS_CNT(2),
        .SWEEP_STEP(32'd100), .SWEEP_MAX(32'd250)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .bitsync(bitsync), .pd(pd),
        .sweep_freq(sweep_freq), .gain_sel(gain_sel), .freeze(freeze),
        .lock(lock), .state(state)
`ifdef CLC_ERR_MON_EN
        , .err_mean(err_mean), .err_valid(err_valid)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [1:0] st;
        int         sw;
        logic [1:0] gs;
        logic       fr;
        logic       lk;
    } exp_t;

    typedef struct {
        int     due;
        longint mean;
    } err_t;

    exp_t  exp_q[$];
    string name_q[$];
    err_t  err_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int due, input logic [1:0] st, input int sw,
                              input logic [1:0] gs, input logic fr, input logic lk,
                              input string nm);
        exp_t e;
        e.due = due; e.st = st; e.sw = sw; e.gs = gs; e.fr = fr; e.lk = lk;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    function automatic longint abs_sat(input logic signed [33:0] v);
        if (v == PD_MIN) return 64'd8589934591;
        if (v < 0) return -longint'(v);
        return longint'(v);
    endfunction

    task automatic symbol(input logic signed [33:0] v);
        bitsync = 1'b1;
        pd      = v;
        tick(1);
        bitsync = 1'b0;
        tick(7);
    endtask

    // Last sample strobe lands 2 clks after its bitsync edge; the FSM
    // reacts one clk after that, so outputs settle 4 edges after the drive.
    task automatic window(input logic signed [33:0] p0, input logic signed [33:0] p1,
                          input logic signed [33:0] p2, input logic signed [33:0] p3,
                          input logic [1:0] st, input int sw, input logic [1:0] gs,
                          input logic fr, input logic lk, input string nm);
        err_t er;
        symbol(p0);
        symbol(p1);
        symbol(p2);
        expect_out(cyc + 4, st, sw, gs, fr, lk, nm);
        er.due  = cyc + 3;
        er.mean = (abs_sat(p0) + abs_sat(p1) + abs_sat(p2) + abs_sat(p3)) >>> 2;
`ifdef CLC_ERR_MON_EN
        err_q.push_back(er);
`endif
        symbol(p3);
    endtask

    task automatic win4(input logic signed [33:0] v, input logic [1:0] st, input int sw,
                        input logic [1:0] gs, input logic fr, input logic lk,
                        input string nm);
        window(v, v, v, v, st, sw, gs, fr, lk, nm);
    endtask

    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (state !== e.st || sweep_freq !== e.sw || gain_sel !== e.gs ||
                freeze !== e.fr || lock !== e.lk) begin
                errors++;
                $display("FAIL %s @cyc %0d: got state=%0d sweep=%0d gain=%0d freeze=%0b lock=%0b, expected state=%0d sweep=%0d gain=%0d freeze=%0b lock=%0b",
                         nm, cyc, state, sweep_freq, gain_sel, freeze, lock,
                         e.st, e.sw, e.gs, e.fr, e.lk);
            end
        end
`ifdef CLC_ERR_MON_EN
        if (err_valid === 1'b1) begin
            err_t er;
            checks++;
            if (err_q.size() == 0) begin
                errors++;
                $display("FAIL err_valid_unexpected @cyc %0d: got err_valid=1, expected 0", cyc);
            end else begin
                er = err_q.pop_front();
                if (longint'(err_mean) != er.mean || cyc != er.due) begin
                    errors++;
                    $display("FAIL err_mon @cyc %0d: got err_mean=%0d, expected err_mean=%0d at cyc %0d",
                             cyc, err_mean, er.mean, er.due);
                end
            end
        end
`endif
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        rst     = 1'b0;
        en      = 1'b0;
        bitsync = 1'b0;
        pd      = '0;

        // reset / IDLE with bitsync running
        expect_out(cyc + 1, 2'd0, 0, 2'd0, 1'b1, 1'b0, "reset_hold");
        symbol(34'sd20000000);
        symbol(34'sd20000000);
        rst = 1'b1;
        expect_out(cyc + 1, 2'd0, 0, 2'd0, 1'b1, 1'b0, "idle_en0_a");
        symbol(34'sd20000000);
        expect_out(cyc + 1, 2'd0, 0, 2'd0, 1'b1, 1'b0, "idle_en0_b");
        symbol(34'sd20000000);
        symbol(34'sd20000000);

        // sweep with wrap
        en = 1'b1;
        expect_out(cyc + 1, 2'd1, 0, 2'd0, 1'b1, 1'b0, "en_to_sweep");
        tick(1);
        win4(34'sd20000000, 2'd1,  100, 2'd0, 1'b1, 1'b0, "sweep_100");
        win4(34'sd20000000, 2'd1,  200, 2'd0, 1'b1, 1'b0, "sweep_200");
        win4(34'sd20000000, 2'd1, -250, 2'd0, 1'b1, 1'b0, "sweep_wrap");
        win4(34'sd20000000, 2'd1, -150, 2'd0, 1'b1, 1'b0, "sweep_m150");

        // acquire
        win4(-34'sd1000000, 2'd2, -150, 2'd1, 1'b0, 1'b0, "pull");
        win4(-34'sd1000000, 2'd3, -150, 2'd2, 1'b0, 1'b1, "track");

        // loss
        win4(34'sd20000000, 2'd3, -150, 2'd2, 1'b0, 1'b1, "track_bad1");
        win4(34'sd1000000,  2'd3, -150, 2'd2, 1'b0, 1'b1, "track_good_clr");
        win4(34'sd20000000, 2'd3, -150, 2'd2, 1'b0, 1'b1, "track_bad1_again");
        win4(34'sd20000000, 2'd1, -150, 2'd0, 1'b1, 1'b0, "loss_to_sweep");

        // hold band and pull failure
        win4(34'sd5000000,  2'd1,  -50, 2'd0, 1'b1, 1'b0, "sweep_neither");
        win4(-34'sd1000000, 2'd2,  -50, 2'd1, 1'b0, 1'b0, "pull_again");
        win4(34'sd5000000,  2'd2,  -50, 2'd1, 1'b0, 1'b0, "pull_neither");
        win4(34'sd20000000, 2'd1,  -50, 2'd0, 1'b1, 1'b0, "pull_bad");
        win4(-34'sd1000000, 2'd2,  -50, 2'd1, 1'b0, 1'b0, "pull_third");
        win4(34'sd5000000,  2'd2,  -50, 2'd1, 1'b0, 1'b0, "pull_neither2");
        win4(-34'sd1000000, 2'd3,  -50, 2'd2, 1'b0, 1'b1, "track_again");

        // disable from TRACK
        en = 1'b0;
        expect_out(cyc + 1, 2'd0, 0, 2'd0, 1'b1, 1'b0, "en_off_track");
        tick(2);
        en = 1'b1;
        expect_out(cyc + 1, 2'd1, 0, 2'd0, 1'b1, 1'b0, "en_on_2");
        tick(1);

        // saturated |pd|, then disable mid-window
        win4(PD_MIN, 2'd1, 100, 2'd0, 1'b1, 1'b0, "sat_bad");
        symbol(PD_MIN);
        symbol(PD_MIN);
        en = 1'b0;
        expect_out(cyc + 1, 2'd0, 0, 2'd0, 1'b1, 1'b0, "en_off_mid");
        tick(2);
        en = 1'b1;
        expect_out(cyc + 1, 2'd1, 0, 2'd0, 1'b1, 1'b0, "en_on_3");
        tick(1);
        win4(-34'sd1000000, 2'd2, 0, 2'd1, 1'b0, 1'b0, "acc_cleared");

        // small-value window (mean 10)
        en = 1'b0;
        tick(2);
        en = 1'b1;
        tick(1);
        window(34'sd4, -34'sd8, 34'sd12, -34'sd16, 2'd2, 0, 2'd1, 1'b0, 1'b0, "mean10_pull");

        tick(10);
        checks++;
        if (exp_q.size() != 0 || err_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending output and %0d pending monitor expectations, expected 0",
                     exp_q.size(), err_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
